// File: rtl/filter_stream_src.sv
// ----------------------------------------------------------------------------
// filter_stream_src
//
// Purpose:
//   Job sequencer that feeds a downstream filter. On a start request it pulses
//   po_start_c_load, streams pi_filt_ord+1 coefficient words from the
//   coefficient memory, then streams pi_num_samples words from the sample
//   memory, and finishes with a one-cycle po_done pulse. Each word is fetched
//   (read enable), captured (memory has 1-cycle read latency) and presented
//   on a valid/ready stream, so one word moves every three cycles at best.
//
//   Coefficient addressing restarts at 0 for every job. The sample address is
//   a ring pointer that continues from where the previous job stopped and
//   wraps from SMP_DEPTH-1 to 0; only reset returns it to 0.
//
// Optional feature (macro FILTER_SRC_LDDONE_WAIT_EN):
//   defined   : after the last coefficient the sequencer waits for pi_lddone.
//               If pi_err is high with pi_lddone, the job aborts with po_err.
//   undefined : the wait lasts one cycle and pi_lddone/pi_err are ignored.
//
// Ports:
//   pi_clk, pi_sreset        clock, synchronous active-high reset
//   pi_start                 job request (sampled only while idle)
//   pi_filt_ord[9:0]         filter order, coefficient count = order+1
//   pi_num_samples[15:0]     number of samples to stream
//   pi_tready                downstream ready
//   pi_lddone, pi_err        filter coefficient-load done / load error
//   po_coef_ren/addr,
//   pi_coef_data             coefficient memory read port
//   po_smp_ren/addr,
//   pi_smp_data              sample memory read port
//   po_tdata/tvalid/tlast    output stream
//   po_start_c_load          one-cycle pulse at job start
//   po_busy                  high whenever not idle
//   po_done                  one-cycle job-complete pulse
//   po_err                   sticky error, cleared by the next accepted start
// ----------------------------------------------------------------------------
module filter_stream_src #(
    parameter  int DATA_WIDTH = 24,
    parameter  int COEF_DEPTH = 512,
    parameter  int SMP_DEPTH  = 1024,
    localparam int COEF_AW    = $clog2(COEF_DEPTH),
    localparam int SMP_AW     = $clog2(SMP_DEPTH)
) (
    input  logic                  pi_clk,
    input  logic                  pi_sreset,
    input  logic                  pi_start,
    input  logic [9:0]            pi_filt_ord,
    input  logic [15:0]           pi_num_samples,
    input  logic                  pi_tready,
    input  logic                  pi_lddone,
    input  logic                  pi_err,
    output logic                  po_coef_ren,
    output logic [COEF_AW-1:0]    po_coef_addr,
    input  logic [DATA_WIDTH-1:0] pi_coef_data,
    output logic                  po_smp_ren,
    output logic [SMP_AW-1:0]     po_smp_addr,
    input  logic [DATA_WIDTH-1:0] pi_smp_data,
    output logic [DATA_WIDTH-1:0] po_tdata,
    output logic                  po_tvalid,
    output logic                  po_tlast,
    output logic                  po_start_c_load,
    output logic                  po_busy,
    output logic                  po_done,
    output logic                  po_err
);

    typedef enum logic [3:0] {
        IDLE, START, C_FETCH, C_CAPT, C_SEND,
        LD_WAIT, S_FETCH, S_CAPT, S_SEND, DONE
    } state_t;

    state_t                r_state;
    logic [9:0]            r_filt_ord;
    logic [15:0]           r_num_smp;
    logic [15:0]           r_smp_cnt;
    logic [COEF_AW-1:0]    r_coef_addr;
    logic [SMP_AW-1:0]     r_smp_addr;
    logic                  r_coef_ren;
    logic                  r_smp_ren;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic                  r_start_c_load;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic w_ord_ok;
    logic w_job_ok;
    logic w_coef_last;
    logic w_smp_last;
    logic w_smp_wrap;

    // An order of COEF_DEPTH or more would index past the coefficient memory.
    assign w_ord_ok    = (32'(pi_filt_ord) < COEF_DEPTH);
    assign w_job_ok    = w_ord_ok && (pi_num_samples != 16'd0);
    assign w_coef_last = (32'(r_coef_addr) == 32'(r_filt_ord));
    // r_num_smp is never zero inside a job, so the subtraction cannot wrap.
    assign w_smp_last  = (r_smp_cnt == (r_num_smp - 16'd1));
    assign w_smp_wrap  = (r_smp_addr == SMP_AW'(SMP_DEPTH - 1));

`ifndef FILTER_SRC_LDDONE_WAIT_EN
    logic w_unused_ld;
    assign w_unused_ld = pi_lddone | pi_err;
`endif

    always_ff @(posedge pi_clk) begin
        if (pi_sreset) begin
            r_state        <= IDLE;
            r_filt_ord     <= '0;
            r_num_smp      <= '0;
            r_smp_cnt      <= '0;
            r_coef_addr    <= '0;
            r_smp_addr     <= '0;
            r_coef_ren     <= 1'b0;
            r_smp_ren      <= 1'b0;
            r_tdata        <= '0;
            r_tvalid       <= 1'b0;
            r_tlast        <= 1'b0;
            r_start_c_load <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (pi_start) begin
                        r_busy <= 1'b1;
                        if (w_job_ok) begin
                            r_state        <= START;
                            r_err          <= 1'b0;
                            r_filt_ord     <= pi_filt_ord;
                            r_num_smp      <= pi_num_samples;
                            r_coef_addr    <= '0;
                            r_smp_cnt      <= '0;
                            r_start_c_load <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                        end
                    end
                end
                START: begin
                    r_start_c_load <= 1'b0;
                    r_coef_ren     <= 1'b1;
                    r_state        <= C_FETCH;
                end
                C_FETCH: begin
                    r_coef_ren <= 1'b0;
                    r_state    <= C_CAPT;
                end
                C_CAPT: begin
                    r_tdata  <= pi_coef_data;
                    r_tvalid <= 1'b1;
                    r_tlast  <= w_coef_last;
                    r_state  <= C_SEND;
                end
                C_SEND: begin
                    if (pi_tready) begin
                        r_tvalid    <= 1'b0;
                        r_tlast     <= 1'b0;
                        r_coef_addr <= r_coef_addr + 1'b1;
                        if (r_tlast) begin
                            r_state <= LD_WAIT;
                        end else begin
                            r_coef_ren <= 1'b1;
                            r_state    <= C_FETCH;
                        end
                    end
                end
                LD_WAIT: begin
`ifdef FILTER_SRC_LDDONE_WAIT_EN
                    if (pi_lddone) begin
                        if (pi_err) begin
                            r_state <= DONE;
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_smp_ren <= 1'b1;
                            r_state   <= S_FETCH;
                        end
                    end
`else
                    r_smp_ren <= 1'b1;
                    r_state   <= S_FETCH;
`endif
                end
                S_FETCH: begin
                    r_smp_ren <= 1'b0;
                    r_state   <= S_CAPT;
                end
                S_CAPT: begin
                    r_tdata  <= pi_smp_data;
                    r_tvalid <= 1'b1;
                    r_tlast  <= w_smp_last;
                    r_state  <= S_SEND;
                end
                S_SEND: begin
                    if (pi_tready) begin
                        r_tvalid   <= 1'b0;
                        r_tlast    <= 1'b0;
                        r_smp_cnt  <= r_smp_cnt + 16'd1;
                        r_smp_addr <= w_smp_wrap ? '0 : r_smp_addr + 1'b1;
                        if (r_tlast) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_smp_ren <= 1'b1;
                            r_state   <= S_FETCH;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign po_coef_ren     = r_coef_ren;
    assign po_coef_addr    = r_coef_addr;
    assign po_smp_ren      = r_smp_ren;
    assign po_smp_addr     = r_smp_addr;
    assign po_tdata        = r_tdata;
    assign po_tvalid       = r_tvalid;
    assign po_tlast        = r_tlast;
    assign po_start_c_load = r_start_c_load;
    assign po_busy         = r_busy;
    assign po_done         = r_done;
    assign po_err          = r_err;

endmodule

// File: tb/tb_filter_stream_src.sv
// ----------------------------------------------------------------------------
// tb_filter_stream_src
//
// Directed bench for filter_stream_src. Memories are modelled so that each
// coefficient word is 0xC00000+address and each sample word is
// 0x500000+address, which makes every streamed word identify its source.
// ----------------------------------------------------------------------------
module tb_filter_stream_src;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  filt_ord;
    logic [15:0] num_smp;
    logic        tready;
    logic        lddone;
    logic        lderr;
    logic        coef_ren;
    logic [8:0]  coef_addr;
    logic [23:0] coef_data = '0;
    logic        smp_ren;
    logic [9:0]  smp_addr;
    logic [23:0] smp_data = '0;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        start_c_load;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [23:0] q_data[$];
    logic        q_last[$];
    int          q_cyc[$];
    logic [9:0]  q_saddr[$];
    int          cyc = 0;
    int          n_done = 0;
    int          n_cload = 0;

    filter_stream_src dut (
        .pi_clk          (clk),
        .pi_sreset       (rst),
        .pi_start        (start),
        .pi_filt_ord     (filt_ord),
        .pi_num_samples  (num_smp),
        .pi_tready       (tready),
        .pi_lddone       (lddone),
        .pi_err          (lderr),
        .po_coef_ren     (coef_ren),
        .po_coef_addr    (coef_addr),
        .pi_coef_data    (coef_data),
        .po_smp_ren      (smp_ren),
        .po_smp_addr     (smp_addr),
        .pi_smp_data     (smp_data),
        .po_tdata        (tdata),
        .po_tvalid       (tvalid),
        .po_tlast        (tlast),
        .po_start_c_load (start_c_load),
        .po_busy         (busy),
        .po_done         (done),
        .po_err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (coef_ren) coef_data <= 24'hC00000 | 24'(coef_addr);
        if (smp_ren)  smp_data  <= 24'h500000 | 24'(smp_addr);
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && tvalid && tready) begin
            q_data.push_back(tdata);
            q_last.push_back(tlast);
            q_cyc.push_back(cyc);
        end
        if (!rst && smp_ren) q_saddr.push_back(smp_addr);
        if (done) n_done = n_done + 1;
        if (start_c_load) n_cload = n_cload + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input int ord, input int n);
        filt_ord = 10'(ord);
        num_smp  = 16'(n);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int cnt;
        cnt = 0;
        while (!done && cnt < bound) begin
            tick();
            cnt++;
        end
        chk({tag, "_done_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic wait_word(input string tag, input int nwords, input int bound);
        int cnt;
        cnt = 0;
        while (!(tvalid && q_data.size() == nwords) && cnt < bound) begin
            tick();
            cnt++;
        end
        chk({tag, "_word_timeout"}, 32'(tvalid), 32'd1);
    endtask

    task automatic check_words(input string tag, input int base, input int ord,
                               input int n, input int sbase);
        int exp_d;
        int exp_l;
        chk({tag, "_count"}, 32'(q_data.size() - base), 32'(ord + 1 + n));
        for (int i = 0; i < ord + 1 + n; i++) begin
            if (base + i < q_data.size()) begin
                if (i <= ord) begin
                    exp_d = 'hC00000 + i;
                    exp_l = (i == ord) ? 1 : 0;
                end else begin
                    exp_d = 'h500000 + ((sbase + i - ord - 1) % 1024);
                    exp_l = (i == ord + n) ? 1 : 0;
                end
                chk({tag, "_data"}, 32'(q_data[base + i]), 32'(exp_d));
                chk({tag, "_last"}, 32'(q_last[base + i]), 32'(exp_l));
            end
        end
    endtask

    initial begin
        int base_w;
        int base_s;
        int base_d;
        int base_c;

        rst      = 1'b1;
        start    = 1'b0;
        filt_ord = '0;
        num_smp  = '0;
        tready   = 1'b1;
        lddone   = 1'b1;
        lderr    = 1'b0;
        tick();
        tick();
        chk("rst_tvalid", 32'(tvalid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_tdata", 32'(tdata), 0);
        chk("rst_tlast", 32'(tlast), 0);
        chk("rst_cload", 32'(start_c_load), 0);
        chk("rst_coef_addr", 32'(coef_addr), 0);
        chk("rst_smp_addr", 32'(smp_addr), 0);
        chk("rst_rens", 32'({coef_ren, smp_ren}), 0);
        rst = 1'b0;
        tick();

        // Basic job, latency, throughput, mid-job input changes ignored.
        base_w = q_data.size(); base_s = q_saddr.size();
        base_d = n_done; base_c = n_cload;
        start_job(3, 2);
        chk("j1_cload", 32'(start_c_load), 1);
        chk("j1_busy", 32'(busy), 1);
        filt_ord = 10'd7;
        num_smp  = 16'd9;
        tick();
        chk("j1_fetch_ren", 32'(coef_ren), 1);
        chk("j1_fetch_addr", 32'(coef_addr), 0);
        chk("j1_cload_off", 32'(start_c_load), 0);
        tick();
        chk("j1_capt_tvalid", 32'(tvalid), 0);
        tick();
        chk("j1_first_tvalid", 32'(tvalid), 1);
        chk("j1_first_tdata", 32'(tdata), 32'hC00000);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("j1", 100);
        chk("j1_err", 32'(err), 0);
        tick();
        chk("j1_busy_end", 32'(busy), 0);
        check_words("j1", base_w, 3, 2, 0);
        chk("j1_n_done", 32'(n_done - base_d), 1);
        chk("j1_n_cload", 32'(n_cload - base_c), 1);
        chk("j1_thru", 32'(q_cyc[base_w + 1] - q_cyc[base_w]), 3);
        chk("j1_saddr0", 32'(q_saddr[base_s]), 0);
        chk("j1_saddr1", 32'(q_saddr[base_s + 1]), 1);

        // Back-pressure on coefficient word 1.
        base_w = q_data.size();
        start_job(3, 1);
        wait_word("j2", base_w + 1, 50);
        tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("j2_hold_tvalid", 32'(tvalid), 1);
            chk("j2_hold_tdata", 32'(tdata), 32'hC00001);
        end
        tready = 1'b1;
        wait_done("j2", 100);
        tick();
        check_words("j2", base_w, 3, 1, 2);

        // Zero sample count and out-of-range order are rejected.
        base_d = n_done; base_c = n_cload;
        start_job(2, 0);
        chk("n0_done", 32'(done), 1);
        chk("n0_err", 32'(err), 1);
        chk("n0_cload", 32'(start_c_load), 0);
        tick();
        chk("n0_done_pulse", 32'(done), 0);
        chk("n0_busy", 32'(busy), 0);
        chk("n0_err_sticky", 32'(err), 1);
        chk("n0_n_cload", 32'(n_cload - base_c), 0);
        chk("n0_n_done", 32'(n_done - base_d), 1);
        start_job(600, 1);
        chk("ord_done", 32'(done), 1);
        chk("ord_err", 32'(err), 1);
        tick();

        // Advance the sample ring pointer to 1022, then check wrap-around.
        base_w = q_data.size();
        start_job(0, 1019);
        chk("big_err_clr", 32'(err), 0);
        wait_done("big", 5000);
        tick();
        chk("big_count", 32'(q_data.size() - base_w), 1020);
        chk("big_last", 32'(q_last[q_last.size() - 1]), 1);
        chk("big_end_addr", 32'(smp_addr), 1022);
        base_w = q_data.size(); base_s = q_saddr.size();
        start_job(1, 4);
        wait_done("wrap", 100);
        tick();
        check_words("wrap", base_w, 1, 4, 1022);
        chk("wrap_sa0", 32'(q_saddr[base_s]), 1022);
        chk("wrap_sa1", 32'(q_saddr[base_s + 1]), 1023);
        chk("wrap_sa2", 32'(q_saddr[base_s + 2]), 0);
        chk("wrap_sa3", 32'(q_saddr[base_s + 3]), 1);

        // Reset while a sample word is stalled in the handshake.
        base_w = q_data.size();
        start_job(0, 3);
        wait_word("rs", base_w + 1, 50);
        tready = 1'b0;
        tick();
        chk("rs_pre_tvalid", 32'(tvalid), 1);
        rst = 1'b1;
        tick();
        chk("rs_tvalid", 32'(tvalid), 0);
        chk("rs_busy", 32'(busy), 0);
        chk("rs_coef_addr", 32'(coef_addr), 0);
        chk("rs_smp_addr", 32'(smp_addr), 0);
        chk("rs_tdata", 32'(tdata), 0);
        chk("rs_count", 32'(q_data.size() - base_w), 1);
        rst    = 1'b0;
        tready = 1'b1;
        tick();

        // Load-done together with load-error.
        base_w = q_data.size(); base_s = q_saddr.size(); base_d = n_done;
        lderr = 1'b1;
        start_job(1, 2);
        wait_done("le", 100);
`ifdef FILTER_SRC_LDDONE_WAIT_EN
        chk("le_err", 32'(err), 1);
`else
        chk("le_err", 32'(err), 0);
`endif
        tick();
        lderr = 1'b0;
`ifdef FILTER_SRC_LDDONE_WAIT_EN
        chk("le_count", 32'(q_data.size() - base_w), 2);
        chk("le_smp_reads", 32'(q_saddr.size() - base_s), 0);
`else
        check_words("le", base_w, 1, 2, 0);
        chk("le_smp_reads", 32'(q_saddr.size() - base_s), 2);
`endif
        chk("le_n_done", 32'(n_done - base_d), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
